range_counter: RTL and testbench
================================

# range_counter

Parametrised, runtime-configurable step counter that generalises the fixed-range counters (0→40 by 2, 350→371 by 3, 93→5 by 4, 22525→22535 by 1) into one block. Width is set by parameter. Start, limit, step, direction and end-of-range mode are set by ports. It sits beside the flip-flop and counter library as the reusable sequencing primitive for lab datapaths. Over-range detection is exact, so a sequence never skips its last legal value or runs past its limit.

## Interface
- `WIDTH`, default 16: count and bound width.
- `STEP_W`, default 4: step width (unsigned).
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous reset, active-low (`rst`=0 resets).
- `clr`  input  1  synchronous clear, active-high.
- `load`  input  1  synchronous load of `start`, active-high.
- `en`  input  1  advance one step this cycle.
- `start`  input  WIDTH  home value.
- `limit`  input  WIDTH  far bound (inclusive).
- `step`  input  STEP_W  increment magnitude.
- `dir`  input  1  1 = count up toward `limit`, 0 = count down toward `limit`.
- `mode`  input  2  0 WRAP, 1 ONESHOT, 2 BOUNCE, 3 reserved (behaves as WRAP).
- `count`  output  WIDTH  current value.
- `wrap`  output  1  one-cycle pulse when an end-of-range reload or turnaround occurs.
- `done`  output  1  level; ONESHOT reached its end and is halted.

## Operation
- Priority per edge: `rst` > `clr` > `load` > `en`. No action when all are idle; `count` holds.
- `clr`: `count`←0, `done`←0, `wrap`←0, internal direction `cur_dir`←`dir`.
- `load`: `count`←`start`, `done`←0, `cur_dir`←`dir`, `wrap`←0.
- `en` (and not `done`): candidate = `count`±`step`, computed in WIDTH+1 bits.
  - Up: overshoot if candidate > `limit` or carry out.
  - Down: overshoot if `count` < `step` or candidate < `limit`.
- No overshoot: `count`←candidate.
- Overshoot, by mode:
  - WRAP: `count`←`start`, `wrap`←1.
  - ONESHOT: `count` holds, `done`←1, `wrap` stays 0.
  - BOUNCE: `cur_dir` flips and `count` steps once in the new direction, `wrap`←1. The return leg turns around at `start`, using the same rule with `start` as its bound. If both directions overshoot, `count` holds and `wrap` still pulses.
- WRAP and ONESHOT use `dir` live each cycle. BOUNCE uses `cur_dir`.
- `step`=0: `count` holds, no overshoot, no `wrap`.
- `start` already beyond `limit` in the counting direction: the first `en` overshoots. WRAP then reloads `start` and pulses `wrap` on every enabled cycle.
- `start`, `limit`, `step` and `mode` are sampled every edge. A change mid-run takes effect on the next update and does not reset state.

## Timing
- Reset values: `count`=0, `wrap`=0, `done`=0, `cur_dir`=1.
- Reset acts immediately on `rst` falling. It is released synchronously by the first edge with `rst`=1. Reset mid-sequence discards all state.
- Latency is one cycle: `count` changes on the edge that samples `en`/`load`/`clr`.
- `wrap` is registered. It is high exactly during the cycle in which `count` first shows the reloaded or turned-around value, and low the next cycle unless a new overshoot occurs.
- `done` rises on the edge on which ONESHOT overshoots. It stays high until `clr` or `load`. `en` is ignored while `done`=1.
- `load` and `en` asserted together: `load` wins, no step.

## Structure
- Package `range_counter_pkg`: `mode_t` enum constants (MODE_WRAP=0, MODE_ONESHOT=1, MODE_BOUNCE=2).
- One combinational sub-module, `range_step_calc`.
  - Inputs: `count`, `step`, bound, direction.
  - Outputs: candidate and overshoot flag, in WIDTH+1 arithmetic.
  - Instantiated twice: current direction and reversed direction, the latter for BOUNCE.
- Top level holds the `count`, `cur_dir`, `wrap` and `done` registers and the priority mux.

## Test plan
- WRAP up, start=0, limit=40, step=2, dir=1, `load` then `en` constant: 0,2,…,40,0. `wrap` high only on the cycle showing 0 after 40. Period 21 cycles.
- WRAP down, start=93, limit=5, step=4, dir=0: 93,89,…,5,93. Then start=350, limit=371, step=3, up: 350,…,371,350.
- ONESHOT up, start=22525, limit=22535, step=1: reaches 22535, `done`=1 next edge, `count` holds at 22535 with `en` high. `load` clears `done`.
- BOUNCE, WIDTH=8, start=10, limit=20, step=4, dir=1: 10,14,18,14,10,14,… `wrap` pulses on the first 14 after 18 and on the 14 after 10. Overflow check with WIDTH=8, start=250, limit=255, step=4: 250,254, then the overshoot is detected and the counter does not wrap to 2.
- Async reset mid-count at value 18 with `clk` stopped: `count`=0, `wrap`=0, `done`=0 immediately. `clr`+`load`+`en` asserted together → `count`=0.
- Edge cases: `step`=0 holds with no `wrap`. start=50 > limit=40 in WRAP up gives `count`=50 and `wrap`=1 every enabled cycle. `limit` changed mid-run from 40 to 20 while `count`=30 gives wrap to `start` on the next `en`.

Source files
------------

// File: rtl/range_counter_pkg.sv
// Shared types for the range_counter block.
// The encodings match the 2-bit value on the mode port.
package range_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_ONESHOT = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_t;

endpackage

// File: rtl/range_step_calc.sv
// Combinational one-step calculator for range_counter.
// Produces the next candidate value and an exact overshoot flag, using WIDTH+1 bit arithmetic.
module range_step_calc #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  i_count,
  input  logic [STEP_W-1:0] i_step,
  input  logic [WIDTH-1:0]  i_bound,
  input  logic              i_dir_up,
  output logic [WIDTH:0]    o_cand,
  output logic              o_over
);

  logic [WIDTH:0] w_count_x;
  logic [WIDTH:0] w_step_x;
  logic [WIDTH:0] w_bound_x;

  assign w_count_x = {1'b0, i_count};
  assign w_step_x  = {{(WIDTH + 1 - STEP_W){1'b0}}, i_step};
  assign w_bound_x = {1'b0, i_bound};

  // The extra top bit catches carry (up) and borrow (down) so no step can silently wrap.
  always_comb begin
    o_cand = w_count_x;
    o_over = 1'b0;
    if (i_dir_up) begin
      o_cand = w_count_x + w_step_x;
      o_over = (o_cand > w_bound_x);
    end else begin
      o_cand = w_count_x - w_step_x;
      o_over = (w_count_x < w_step_x) || (o_cand < w_bound_x);
    end
  end

endmodule

// File: rtl/range_counter.sv
// Runtime-configurable step counter with WRAP, ONESHOT and BOUNCE end-of-range handling.
// Priority per edge is rst > clr > load > en; all outputs are registered.
module range_counter
  import range_counter_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              en,
  input  logic [WIDTH-1:0]  start,
  input  logic [WIDTH-1:0]  limit,
  input  logic [STEP_W-1:0] step,
  input  logic              dir,
  input  logic [1:0]        mode,
  output logic [WIDTH-1:0]  count,
  output logic              wrap,
  output logic              done
);

  logic [WIDTH-1:0] r_count;
  logic             r_cur_dir;
  logic             r_wrap;
  logic             r_done;

  logic [WIDTH-1:0] w_count_nxt;
  logic             w_cur_dir_nxt;
  logic             w_wrap_nxt;
  logic             w_done_nxt;

  mode_t            w_mode;
  logic             w_bounce;
  logic             w_out_leg;
  logic             w_fwd_dir;
  logic [WIDTH-1:0] w_fwd_bound;
  logic [WIDTH-1:0] w_rev_bound;
  logic [WIDTH:0]   w_fwd_cand;
  logic             w_fwd_over;
  logic [WIDTH:0]   w_rev_cand;
  logic             w_rev_over;
  logic             w_step_nz;

  assign w_mode    = mode_t'(mode);
  assign w_bounce  = (w_mode == MODE_BOUNCE);
  assign w_step_nz = |step;

  // In BOUNCE the outbound leg (cur_dir == dir) heads for limit, the return leg for start.
  assign w_out_leg   = (r_cur_dir == dir);
  assign w_fwd_dir   = w_bounce ? r_cur_dir : dir;
  assign w_fwd_bound = (w_bounce && !w_out_leg) ? start : limit;
  assign w_rev_bound = w_out_leg ? start : limit;

  range_step_calc #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_calc_fwd (
    .i_count  (r_count),
    .i_step   (step),
    .i_bound  (w_fwd_bound),
    .i_dir_up (w_fwd_dir),
    .o_cand   (w_fwd_cand),
    .o_over   (w_fwd_over)
  );

  range_step_calc #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_calc_rev (
    .i_count  (r_count),
    .i_step   (step),
    .i_bound  (w_rev_bound),
    .i_dir_up (~r_cur_dir),
    .o_cand   (w_rev_cand),
    .o_over   (w_rev_over)
  );

  // Next-state priority mux: clr, then load, then an enabled non-zero step.
  always_comb begin
    w_count_nxt   = r_count;
    w_cur_dir_nxt = r_cur_dir;
    w_wrap_nxt    = 1'b0;
    w_done_nxt    = r_done;
    if (clr) begin
      w_count_nxt   = {WIDTH{1'b0}};
      w_cur_dir_nxt = dir;
      w_done_nxt    = 1'b0;
    end else if (load) begin
      w_count_nxt   = start;
      w_cur_dir_nxt = dir;
      w_done_nxt    = 1'b0;
    end else if (en && !r_done && w_step_nz) begin
      if (!w_fwd_over) begin
        w_count_nxt = w_fwd_cand[WIDTH-1:0];
      end else begin
        case (w_mode)
          MODE_ONESHOT: begin
            w_done_nxt = 1'b1;
          end
          MODE_BOUNCE: begin
            // Turnaround always pulses wrap; count only moves if the reverse step is legal.
            w_cur_dir_nxt = ~r_cur_dir;
            w_wrap_nxt    = 1'b1;
            if (!w_rev_over) begin
              w_count_nxt = w_rev_cand[WIDTH-1:0];
            end else begin
              w_count_nxt = r_count;
            end
          end
          default: begin
            w_count_nxt = start;
            w_wrap_nxt  = 1'b1;
          end
        endcase
      end
    end else begin
      w_wrap_nxt = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count   <= {WIDTH{1'b0}};
      r_cur_dir <= 1'b1;
      r_wrap    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_cur_dir <= w_cur_dir_nxt;
      r_wrap    <= w_wrap_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign done  = r_done;

endmodule

// File: tb/tb_range_counter.sv
// Scoreboard bench for range_counter: the driver queues expected outputs after each edge,
// and an independent monitor pops and compares them on the following falling edge.
module tb_range_counter;

  localparam int WIDTH  = 16;
  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  bit                clk_en = 1'b1;
  logic              rst;
  logic              clr;
  logic              load;
  logic              en;
  logic [WIDTH-1:0]  start;
  logic [WIDTH-1:0]  limit;
  logic [STEP_W-1:0] step;
  logic              dir;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  count;
  logic              wrap;
  logic              done;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] c;
    logic             w;
    logic             d;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  event sample_ev;

  range_counter #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .load  (load),
    .en    (en),
    .start (start),
    .limit (limit),
    .step  (step),
    .dir   (dir),
    .mode  (mode),
    .count (count),
    .wrap  (wrap),
    .done  (done)
  );

  always #5 if (clk_en) clk = ~clk;

  // Monitor: compares DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_ev);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (count === e.c && wrap === e.w && done === e.d) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got count=%0d wrap=%0b done=%0b, expected count=%0d wrap=%0b done=%0b",
                   e.tag, count, wrap, done, e.c, e.w, e.d);
        end
      end
    end
  end

  task automatic cyc(input string t, input int c, input logic w, input logic d);
    exp_t e;
    @(posedge clk);
    #1;
    e.tag = t;
    e.c   = c[WIDTH-1:0];
    e.w   = w;
    e.d   = d;
    sb_q.push_back(e);
  endtask

  task automatic cfg(input int s, input int l, input int st, input logic di, input logic [1:0] m);
    start = s[WIDTH-1:0];
    limit = l[WIDTH-1:0];
    step  = st[STEP_W-1:0];
    dir   = di;
    mode  = m;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0;
    cfg(0, 0, 0, 1'b1, 2'd0);
    cyc("reset", 0, 1'b0, 1'b0);
    cyc("reset", 0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc("idle_hold", 0, 1'b0, 1'b0);

    // WRAP up 0..40 by 2, period 21
    cfg(0, 40, 2, 1'b1, 2'd0);
    load = 1'b1;
    cyc("wrap_up_load", 0, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    for (int i = 1; i <= 20; i++) cyc("wrap_up", 2 * i, 1'b0, 1'b0);
    cyc("wrap_up_reload", 0, 1'b1, 1'b0);
    cyc("wrap_up_after", 2, 1'b0, 1'b0);

    // WRAP down 93..5 by 4
    en = 1'b0; load = 1'b1;
    cfg(93, 5, 4, 1'b0, 2'd0);
    cyc("wrap_dn_load", 93, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    for (int k = 1; k <= 22; k++) cyc("wrap_dn", 93 - 4 * k, 1'b0, 1'b0);
    cyc("wrap_dn_reload", 93, 1'b1, 1'b0);

    // WRAP up 350..371 by 3
    en = 1'b0; load = 1'b1;
    cfg(350, 371, 3, 1'b1, 2'd0);
    cyc("wrap_350_load", 350, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    for (int k = 1; k <= 7; k++) cyc("wrap_350", 350 + 3 * k, 1'b0, 1'b0);
    cyc("wrap_350_reload", 350, 1'b1, 1'b0);

    // ONESHOT 22525..22535, then load together with en clears done
    en = 1'b0; load = 1'b1;
    cfg(22525, 22535, 1, 1'b1, 2'd1);
    cyc("oneshot_load", 22525, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    for (int k = 1; k <= 10; k++) cyc("oneshot", 22525 + k, 1'b0, 1'b0);
    cyc("oneshot_done", 22535, 1'b0, 1'b1);
    cyc("oneshot_hold", 22535, 1'b0, 1'b1);
    load = 1'b1;
    cyc("oneshot_load_wins", 22525, 1'b0, 1'b0);

    // BOUNCE 10 <-> 20 by 4
    cfg(10, 20, 4, 1'b1, 2'd2);
    cyc("bounce_load", 10, 1'b0, 1'b0);
    load = 1'b0;
    cyc("bounce", 14, 1'b0, 1'b0);
    cyc("bounce", 18, 1'b0, 1'b0);
    cyc("bounce_turn_top", 14, 1'b1, 1'b0);
    cyc("bounce", 10, 1'b0, 1'b0);
    cyc("bounce_turn_bot", 14, 1'b1, 1'b0);
    cyc("bounce", 18, 1'b0, 1'b0);
    cyc("bounce_turn_top2", 14, 1'b1, 1'b0);

    // BOUNCE at the top of the range: carry must be caught, no wrap to 2
    en = 1'b0; load = 1'b1;
    cfg(65530, 65535, 4, 1'b1, 2'd2);
    cyc("ovf_load", 65530, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    cyc("ovf", 65534, 1'b0, 1'b0);
    cyc("ovf_turn", 65530, 1'b1, 1'b0);
    cyc("ovf_turn_bot", 65534, 1'b1, 1'b0);

    // ONESHOT done then clr (clr beats en)
    en = 1'b0; load = 1'b1;
    cfg(0, 2, 2, 1'b1, 2'd1);
    cyc("clr_done_load", 0, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    cyc("clr_done_step", 2, 1'b0, 1'b0);
    cyc("clr_done_set", 2, 1'b0, 1'b1);
    clr = 1'b1;
    cyc("clr_clears_done", 0, 1'b0, 1'b0);
    clr = 1'b0;

    // Async reset at count 18 with clock stopped
    en = 1'b0; load = 1'b1;
    cfg(0, 40, 2, 1'b1, 2'd0);
    cyc("arst_load", 0, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    for (int i = 1; i <= 9; i++) cyc("arst_run", 2 * i, 1'b0, 1'b0);
    en = 1'b0;
    @(negedge clk);
    clk_en = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    sb_q.push_back('{tag: "async_reset", c: '0, w: 1'b0, d: 1'b0});
    -> sample_ev;
    #2;
    rst = 1'b1;
    clk_en = 1'b1;
    clr = 1'b1; load = 1'b1; en = 1'b1;
    start = 16'd7;
    cyc("clr_load_en", 0, 1'b0, 1'b0);
    clr = 1'b0; load = 1'b0; en = 1'b0;

    // step = 0 holds without wrap
    load = 1'b1;
    cfg(5, 40, 0, 1'b1, 2'd0);
    cyc("step0_load", 5, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    cyc("step0_hold", 5, 1'b0, 1'b0);
    cyc("step0_hold", 5, 1'b0, 1'b0);

    // start beyond limit: reload and wrap on every enabled cycle
    en = 1'b0; load = 1'b1;
    cfg(50, 40, 2, 1'b1, 2'd0);
    cyc("beyond_load", 50, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) cyc("beyond_wrap", 50, 1'b1, 1'b0);

    // limit lowered mid-run below the current count
    en = 1'b0; load = 1'b1;
    cfg(0, 40, 2, 1'b1, 2'd0);
    cyc("lim_chg_load", 0, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    for (int i = 1; i <= 15; i++) cyc("lim_chg_run", 2 * i, 1'b0, 1'b0);
    limit = 16'd20;
    cyc("lim_chg_wrap", 0, 1'b1, 1'b0);
    cyc("lim_chg_after", 2, 1'b0, 1'b0);
    en = 1'b0;

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
